jc_step_decoder: RTL
====================

Name: jc_step_decoder

Overview:
Receive end of the Johnson-counter LED drive. Samples a W-bit twisted-ring (Johnson) code bus and tracks phase, direction, signed position and run/stop status. Flags illegal codes and skipped steps. Sits on the board-monitor side, fed from the LED-driver pins or a loopback of the counter register, and reports to status/logging logic.

Parameters:
W, 4, Johnson code width; legal sequence length 2*W
SYNC_STAGES, 2, input synchronizer depth (>=2)
POS_W, 8, signed position counter width
IDLE_TIMEOUT, 255, cycles without a step before running deasserts (>=1)
FILTER_LEN, 3, stability cycles required when JCD_GLITCH_FILTER_EN is defined (>=1)

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
jc_in  input  W  raw Johnson code, asynchronous to clk
err_clr  input  1  clears sticky err when high for one cycle
phase  output  $clog2(2*W)  index of last accepted legal code
dir  output  1  1 = forward/left (index+1), 0 = reverse/right (index-1)
step  output  1  one-cycle pulse per accepted single step
pos  output  POS_W  signed step count
running  output  1  step seen within last IDLE_TIMEOUT cycles
locked  output  1  reference code established
err  output  1  sticky illegal-code / skipped-step flag

Behaviour:
- Reset (sync, active-high): phase=0, dir=0, step=0, pos=0, running=0, locked=0, err=0, idle counter=0, FSM=IDLE, sync chain cleared to 0.
- Code index, forward order for W=4: 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7.
  - MSB=0: index = popcount.
  - MSB=1: index = W + count of zeros.
  - Legal only if the code is 0..01..1 or 1..10..0. All other codes are illegal.
- Latency: a jc_in value sampled at edge k appears at the synchronizer output after SYNC_STAGES edges. The decode result (step/phase/pos/err) is registered on the next edge, so the total is SYNC_STAGES+1 edges.
- FSM states are IDLE, TRACK and RESYNC.
  - IDLE: first legal synced code loads phase and sets locked=1, then goes to TRACK. No step, pos unchanged. Illegal codes are ignored (err not set).
  - TRACK, code equals phase: no action.
  - TRACK, index = phase+1 mod 2W: step=1, dir=1, pos+=1.
  - TRACK, index = phase-1 mod 2W: step=1, dir=0, pos-=1.
  - TRACK, illegal code or legal code at distance >=2: err=1, locked=0, go to RESYNC. phase, pos and dir are held.
  - RESYNC: first legal code loads phase, sets locked=1 and returns to TRACK. No step is emitted.
- Wrap-around:
  - phase 2W-1 -> 0 counts as forward.
  - 0 -> 2W-1 counts as reverse.
  - pos wraps modulo 2^POS_W in two's complement, with no saturation.
- Idle counter:
  - Cleared on every step, otherwise increments and saturates at IDLE_TIMEOUT.
  - running=1 on the step cycle.
  - running=0 when the counter reaches IDLE_TIMEOUT.
- err_clr clears err. If err_clr and a new error occur in the same cycle, err=1 (the error wins).
- rst mid-operation aborts any state immediately; the first legal code after reset re-locks via IDLE.
- Direction reversal is a normal step. dir updates on that step.

Optional Feature:
JCD_GLITCH_FILTER_EN
- Defined: after the synchronizer, a candidate code is passed to the decoder only after it has been identical for FILTER_LEN consecutive cycles. Any change restarts the count. Latency becomes SYNC_STAGES+FILTER_LEN+1 edges. Pulses shorter than FILTER_LEN cycles (including single-cycle illegal glitches) are invisible.
- Undefined: the synchronizer output feeds the decoder directly. The FILTER_LEN parameter is present but unused.

Test Plan:
- Reset, then jc_in=0000 held -> locked=1 after 3 edges, phase=0, pos=0, step never pulses, err=0.
- Forward sequence 0000,0001,0011,...,1000,0000 (each held 4 cycles) -> 8 step pulses, dir=1, pos=8, phase=0; wrap 7->0 counts as a step.
- From pos=8/phase=0 apply 1000,1100 -> dir=0, pos=6, phase=6. Then hold 1100 for IDLE_TIMEOUT cycles -> running=0.
- In TRACK at phase=1 (0001), apply 0101 -> err=1, locked=0, pos unchanged. Then 0111 -> locked=1, phase=3, no step. Then 1111 -> step, pos+1. Pulse err_clr -> err=0.
- err_clr asserted in the same cycle a skip (phase 0 -> code 0111) is decoded -> err stays 1.
- With JCD_GLITCH_FILTER_EN, FILTER_LEN=3: 2-cycle 0110 glitch on a steady 0011 -> no err, no step. The same glitch without the macro -> err=1. Assert rst mid-sequence at pos=5 -> pos=0, locked=0 the next cycle.

Source files
------------

// File: rtl/jc_step_decoder.sv
// Johnson-code receive decoder: synchronizes a twisted-ring bus and tracks phase, direction, position and run state.
// Optional glitch filter enabled by defining JCD_GLITCH_FILTER_EN.
module jc_step_decoder #(
  parameter int W            = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int POS_W        = 8,
  parameter int IDLE_TIMEOUT = 255,
  parameter int FILTER_LEN   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [W-1:0]              jc_in,
  input  logic                      err_clr,
  output logic [$clog2(2*W)-1:0]    phase,
  output logic                      dir,
  output logic                      step,
  output logic signed [POS_W-1:0]   pos,
  output logic                      running,
  output logic                      locked,
  output logic                      err
);

  localparam int PW = $clog2(2*W);
  localparam int IW = $clog2(IDLE_TIMEOUT+1);
  localparam logic [PW-1:0] LAST_IDX = PW'(2*W-1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  typedef enum logic [1:0] {IDLE, TRACK, RESYNC} state_t;

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] code;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= jc_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef JCD_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN+1);
  logic [W-1:0]  cand;
  logic [W-1:0]  filt;
  logic [FW-1:0] stable_cnt;
  logic [FW-1:0] stable_nxt;

  // Count includes the current sample, so a new value passes on its FILTER_LEN-th consecutive cycle.
  always_comb begin
    stable_nxt = stable_cnt;
    if (sync_q[SYNC_STAGES-1] != cand) stable_nxt = FW'(1);
    else if (stable_cnt != FW'(FILTER_LEN)) stable_nxt = stable_cnt + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand       <= '0;
      filt       <= '0;
      stable_cnt <= '0;
    end else begin
      cand       <= sync_q[SYNC_STAGES-1];
      stable_cnt <= stable_nxt;
      if (stable_nxt == FW'(FILTER_LEN)) filt <= sync_q[SYNC_STAGES-1];
    end
  end

  assign code = filt;
`else
  assign code = sync_q[SYNC_STAGES-1];
`endif

  function automatic logic [PW-1:0] code_index(input logic [W-1:0] c);
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) if (c[i]) ones++;
    if (c[W-1]) return PW'(2*W - ones);
    else return PW'(ones);
  endfunction

  logic [W-1:0]  code_inv;
  logic          legal;
  logic [PW-1:0] idx;
  logic [PW-1:0] phase_inc;
  logic [PW-1:0] phase_dec;

  // Legal codes are low-filled (2^k-1) or their complement.
  assign code_inv  = ~code;
  assign legal     = ((code & (code + W'(1))) == '0) || ((code_inv & (code_inv + W'(1))) == '0);
  assign idx       = code_index(code);
  assign phase_inc = (phase == LAST_IDX) ? '0 : phase + PW'(1);
  assign phase_dec = (phase == '0) ? LAST_IDX : phase - PW'(1);

  state_t                   state, state_n;
  logic [PW-1:0]            phase_n;
  logic                     dir_n, step_n, locked_n, err_n, err_set, running_n;
  logic signed [POS_W-1:0]  pos_n;
  logic [IW-1:0]            idle_cnt, idle_n;

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    dir_n    = dir;
    step_n   = 1'b0;
    pos_n    = pos;
    locked_n = locked;
    err_set  = 1'b0;
    case (state)
      IDLE, RESYNC: begin
        if (legal) begin
          phase_n  = idx;
          locked_n = 1'b1;
          state_n  = TRACK;
        end
      end
      TRACK: begin
        if (legal && idx == phase) begin
          state_n = TRACK;
        end else if (legal && idx == phase_inc) begin
          phase_n = idx;
          step_n  = 1'b1;
          dir_n   = 1'b1;
          pos_n   = pos + POS_ONE;
        end else if (legal && idx == phase_dec) begin
          phase_n = idx;
          step_n  = 1'b1;
          dir_n   = 1'b0;
          pos_n   = pos - POS_ONE;
        end else begin
          err_set  = 1'b1;
          locked_n = 1'b0;
          state_n  = RESYNC;
        end
      end
      default: state_n = IDLE;
    endcase

    // A fresh error outranks a simultaneous clear request.
    err_n = err_set ? 1'b1 : (err_clr ? 1'b0 : err);

    if (step_n) begin
      idle_n    = '0;
      running_n = 1'b1;
    end else begin
      idle_n    = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IW'(1);
      running_n = running && (idle_n != IDLE_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      dir      <= 1'b0;
      step     <= 1'b0;
      pos      <= '0;
      running  <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
      idle_cnt <= '0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      dir      <= dir_n;
      step     <= step_n;
      pos      <= pos_n;
      running  <= running_n;
      locked   <= locked_n;
      err      <= err_n;
      idle_cnt <= idle_n;
    end
  end

endmodule
